// File: rtl/wb_bram_arbiter_if.sv
// Bus bundle between the two BRAM masters, the arbiter and the BRAM macro.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
interface wb_bram_arbiter_if;
  // port 0: management-SoC Wishbone slave side
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  // port 1: simple req/ack master
  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  // BRAM macro side
  logic        bram_en_o;
  logic [3:0]  bram_we_o;
  logic [31:0] bram_adr_o;
  logic [31:0] bram_dat_o;
  logic [31:0] bram_dat_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  m1_req_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_ack_o, m1_dat_o,
    output bram_en_o, bram_we_o, bram_adr_o, bram_dat_o,
    input  bram_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output m1_req_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_ack_o, m1_dat_o,
    input  bram_en_o, bram_we_o, bram_adr_o, bram_dat_o,
    output bram_dat_i
  );
endinterface

// File: rtl/wb_bram_arbiter.sv
// Two-master arbiter for the user BRAM: Wishbone port 0 and req/ack port 1.
// Each access holds the BRAM enable for DELAYS+1 cycles, then acks for one cycle.
// Build option: define BRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties);
// default is round-robin on ties.
//
// state | meaning
// IDLE  | no access in flight; requests sampled each edge
// BUSY  | BRAM enabled with latched address/data/byte-enables, counting cycles
// ACK   | enable dropped, winner's ack pulses with captured read data
module wb_bram_arbiter #(
  parameter int DELAYS = 10
) (
  input logic             wb_clk_i,
  input logic             wb_rst_n,
  wb_bram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [15:0] LP_DELAYS = 16'(DELAYS);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_last_grant;
  logic        r_grant;
  logic        r_en;
  logic [3:0]  r_we;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_rdata;
  logic        r_ack0;
  logic        r_ack1;

  logic w_req0;
  logic w_req1;
  logic w_pick;
  logic w_ack0;
  logic w_ack1;

  assign w_req0 = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign w_req1 = bus.m1_req_i;

  // choose the winner for a grant in IDLE (0 = port 0, 1 = port 1)
  always_comb begin
    w_pick = 1'b0;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    w_pick = ~w_req0;
`else
    if (w_req0 && w_req1) w_pick = ~r_last_grant;
    else                  w_pick = w_req1;
`endif
  end

  // access sequencer: grant, hold enable for DELAYS+1 cycles, one-cycle ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_en         <= 1'b0;
      r_we         <= '0;
      r_adr        <= '0;
      r_wdat       <= '0;
      r_rdata      <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          if (w_req0 || w_req1) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_cnt        <= '0;
            r_en         <= 1'b1;
            r_state      <= ST_BUSY;
            if (!w_pick) begin
              r_adr  <= bus.wbs_adr_i;
              r_wdat <= bus.wbs_dat_i;
              r_we   <= bus.wbs_sel_i & {4{bus.wbs_we_i}};
            end else begin
              r_adr  <= bus.m1_adr_i;
              r_wdat <= bus.m1_dat_i;
              r_we   <= {4{bus.m1_we_i}};
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == LP_DELAYS) begin
            r_rdata <= bus.bram_dat_i;
            r_en    <= 1'b0;
            r_we    <= '0;
            r_ack0  <= ~r_grant;
            r_ack1  <= r_grant;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_en    <= 1'b0;
          r_we    <= '0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // a master that abandoned its request gets no ack; the BRAM access itself still completed
  assign w_ack0 = r_ack0 & bus.wbs_cyc_i;
  assign w_ack1 = r_ack1 & bus.m1_req_i;

  assign bus.wbs_ack_o  = w_ack0;
  assign bus.wbs_dat_o  = w_ack0 ? r_rdata : 32'd0;
  assign bus.m1_ack_o   = w_ack1;
  assign bus.m1_dat_o   = w_ack1 ? r_rdata : 32'd0;
  assign bus.bram_en_o  = r_en;
  assign bus.bram_we_o  = r_we;
  assign bus.bram_adr_o = r_adr;
  assign bus.bram_dat_o = r_wdat;

endmodule
